alu_op_sequencer: RTL

- Initiator-side controller for the 16-bit ALU. It accepts packed operation words over a valid/ready handshake and reads operands from a 4-entry x 16-bit register file.
- It drives ALU A/B/Cin/Mode from registers, samples Y/Cout/Overflow after a fixed settle latency, and writes Y back to the register file. It also presents the result on a valid/ready output channel.
- It sits between a test or program source and the combinational ALU, and gives the ALU a clocked, handshaked front end.

---
 rtl/alu_op_sequencer_pkg.sv | 29 ++
 rtl/alu_op_regfile.sv | 26 ++
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared widths, FSM and carry-select encodings, op_word fields and ALU mode codes
package alu_op_sequencer_pkg;
  localparam int N = 16;
  localparam int M = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  typedef enum logic [1:0] {CIN_ZERO = 2'd0, CIN_ONE = 2'd1, CIN_FLAG = 2'd2, CIN_RSV = 2'd3} cin_sel_e;
  localparam int OP_MODE_LSB = 8;
  localparam int OP_RD_LSB = 6;
  localparam int OP_RA_LSB = 4;
  localparam int OP_RB_LSB = 2;
  localparam int OP_CIN_LSB = 0;
  localparam logic [3:0] MODE_AND = 4'd0;
  localparam logic [3:0] MODE_OR = 4'd1;
  localparam logic [3:0] MODE_XOR = 4'd2;
  localparam logic [3:0] MODE_NOTA = 4'd3;
  localparam logic [3:0] MODE_ADD = 4'd4;
  localparam logic [3:0] MODE_SUB = 4'd5;
  localparam logic [3:0] MODE_INC = 4'd6;
  localparam logic [3:0] MODE_DEC = 4'd7;
  localparam logic [3:0] MODE_SHL = 4'd8;
  localparam logic [3:0] MODE_SHR = 4'd9;
  localparam logic [3:0] MODE_ROL = 4'd10;
  localparam logic [3:0] MODE_ROR = 4'd11;
  localparam logic [3:0] MODE_NAND = 4'd12;
  localparam logic [3:0] MODE_PASSA = 4'd13;
  localparam logic [3:0] MODE_PASSB = 4'd14;
  localparam logic [3:0] MODE_ZERO = 4'd15;
endpackage

// File: rtl/alu_op_regfile.sv
// alu_op_regfile: 4 x N register file, one write port, two asynchronous read ports
module alu_op_regfile #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [1:0]   raddr_a,
  output logic [N-1:0] rdata_a,
  input  logic [1:0]   raddr_b,
  output logic [N-1:0] rdata_b
);
  logic [N-1:0] mem_q [4];
  logic [N-1:0] mem_d [4];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshaked, clocked front end that issues op words to a combinational ALU and writes results back
module alu_op_sequencer #(
  parameter int N = alu_op_sequencer_pkg::N,
  parameter int M = alu_op_sequencer_pkg::M,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [1:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [11:0]  op_word,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [M-1:0] alu_mode,
  input  logic [N-1:0] alu_y,
  input  logic         alu_cout,
  input  logic         alu_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [1:0]   res_rd,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         flag_c,
  output logic         flag_v
);
  import alu_op_sequencer_pkg::*;
  state_e state_q, state_d;
  logic [11:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [M-1:0] alu_mode_q, alu_mode_d;
  logic alu_cin_q, alu_cin_d, res_valid_q, res_valid_d, res_cout_q, res_cout_d;
  logic res_ovf_q, res_ovf_d, flag_c_q, flag_c_d, flag_v_q, flag_v_d;
  logic [1:0] res_rd_q, res_rd_d, cin_sel;
  logic rf_we;
  logic [1:0] rf_waddr;
  logic [N-1:0] rf_wdata, rf_a, rf_b;
  assign cin_sel = op_q[OP_CIN_LSB +: 2];
  assign ld_ready = state_q == IDLE;
  assign op_ready = state_q == IDLE && !ld_valid;
  alu_op_regfile #(.N(N)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr_a(op_q[OP_RA_LSB +: 2]), .rdata_a(rf_a),
    .raddr_b(op_q[OP_RB_LSB +: 2]), .rdata_b(rf_b)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_cin_d = alu_cin_q;
    alu_mode_d = alu_mode_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    res_rd_d = res_rd_q;
    res_cout_d = res_cout_q;
    res_ovf_d = res_ovf_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    rf_we = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    unique case (state_q)
      IDLE: begin
        rf_we = ld_valid;
        op_d = op_ready && op_valid ? op_word : op_q;
        state_d = op_ready && op_valid ? ISSUE : IDLE;
      end
      ISSUE: begin
        alu_a_d = rf_a;
        alu_b_d = rf_b;
        alu_mode_d = op_q[OP_MODE_LSB +: M];
        alu_cin_d = cin_sel == CIN_ONE ? 1'b1 : cin_sel == CIN_FLAG ? flag_c_q : 1'b0;
        cnt_d = CNT_W'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        if (cnt_q == '0) begin
          res_data_d = alu_y;
          res_rd_d = op_q[OP_RD_LSB +: 2];
          res_cout_d = alu_cout;
          res_ovf_d = alu_ovf;
          res_valid_d = 1'b1;
          flag_c_d = alu_cout;
          flag_v_d = alu_ovf;
          rf_we = 1'b1;
          rf_waddr = op_q[OP_RD_LSB +: 2];
          rf_wdata = alu_y;
          state_d = RESP;
        end
      end
      RESP: begin
        res_valid_d = !res_ready;
        state_d = res_ready ? IDLE : RESP;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_cin_q <= 1'b0;
      alu_mode_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_rd_q <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_mode_q <= alu_mode_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_rd_q <= res_rd_d;
      res_cout_q <= res_cout_d;
      res_ovf_q <= res_ovf_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_cin = alu_cin_q;
  assign alu_mode = alu_mode_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_rd = res_rd_q;
  assign res_cout = res_cout_q;
  assign res_ovf = res_ovf_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
endmodule
